multicycle_core: RTL and testbench
==================================

MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/register/address width; legal values 32 or 64.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset; must be word-aligned.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 0, meaning max wait cycles per memory access before halting; 0 disables the timeout.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_req  output  1  memory access request (instruction or data).
REQ-007 mem_we  output  1  1 = write (sw), 0 = read.
REQ-008 mem_addr  output  XLEN  byte address of the access.
REQ-009 mem_wdata  output  XLEN  store data.
REQ-010 mem_rdata  input  XLEN  read data; instructions use bits [31:0].
REQ-011 mem_ready  input  1  access completes on the edge where mem_req and mem_ready are both 1.
REQ-012 pc_out  output  XLEN  current PC.
REQ-013 alu_out  output  XLEN  registered ALU result of the last EXEC.
REQ-014 retired  output  1  one-cycle pulse per completed instruction.
REQ-015 halted  output  1  core is in HALT.
REQ-016 fault  output  1  sticky; set on memory timeout.

Function
REQ-017 SHALL sequence FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH; HALT is absorbing until reset.
REQ-018 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=PC; on handshake latch IR=mem_rdata[31:0] and PC+4, go to DECODE.
REQ-019 DECODE SHALL latch A=R[rs], B=R[rt] and sign-extended imm[15:0] to XLEN.
REQ-020 Encoding SHALL be op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], target[25:0].
REQ-021 Supported: R-type op 0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); addi 0x08; lw 0x23; sw 0x2B; beq 0x04; j 0x02; halt 0x3F.
REQ-022 Arithmetic SHALL be XLEN-bit two's complement, wrap on overflow, no exception.
REQ-023 R-type/addi: EXEC -> WB; WB writes R[rd] (R-type) or R[rt] (addi), asserts retired, -> FETCH.
REQ-024 lw/sw: EXEC computes A+imm; MEM drives mem_addr=that, mem_we (1 for sw), mem_wdata=B; on handshake lw -> WB writing R[rt]=mem_rdata, sw asserts retired -> FETCH.
REQ-025 beq: in EXEC, if A==B then PC = PC+4 + (imm<<2), else PC+4; retired; -> FETCH.
REQ-026 j: in EXEC, PC = zero-extended {target,2'b00}; retired; -> FETCH.
REQ-027 halt: in EXEC, retired, -> HALT, halted=1; no further mem_req.
REQ-028 Unknown op/funct SHALL retire as NOP (PC+4, no register write).
REQ-029 R[0] SHALL read 0; writes to it are discarded.
REQ-030 mem_addr/mem_we/mem_wdata SHALL be stable while mem_req=1 and not ready; mem_req drops the cycle after handshake.
REQ-031 mem_ready while mem_req=0 SHALL be ignored.
REQ-032 Latency with zero wait: R/addi/lw 4/4/5 cycles, sw/beq/j/halt 4/3/3/3 cycles, FETCH to next FETCH.
REQ-033 If MEM_TIMEOUT>0 and a request waits MEM_TIMEOUT cycles without ready, SHALL set fault, drop mem_req, enter HALT, no retire.
REQ-034 Misaligned addresses SHALL be passed through unchanged (no check).

Reset
REQ-035 On reset: state FETCH, PC=RESET_PC, mem_req=0 that cycle, retired=0, halted=0, fault=0, alu_out=0, all registers 0.
REQ-036 Reset during a pending access SHALL abandon it; first FETCH request issues the cycle after reset deasserts.

Verification
REQ-037 addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 -> r3=2, r4=1, 4 retired pulses.
REQ-038 sw r1,8(r0) then lw r5,8(r0), 3 wait cycles per access -> mem write addr 8 data 5, r5=5, signals stable during waits.
REQ-039 beq r1,r1,+2 at PC 0x10 -> next fetch address 0x1C; beq not taken -> 0x14.
REQ-040 j target 0x40 -> next fetch address 0x100; halt -> halted=1, mem_req stays 0.
REQ-041 MEM_TIMEOUT=4, mem_ready held 0 -> fault=1, halted=1 after 4 wait cycles; reset clears both.
REQ-042 Reset asserted mid-lw wait -> mem_req 0 next cycle, PC=RESET_PC, lw never writes.

Source files
------------

// File: rtl/multicycle_core.sv
// multicycle_core: multicycle MIPS-style core sharing one memory port for fetch and data
module multicycle_core #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] alu_out,
  output logic            retired,
  output logic            halted,
  output logic            fault
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  logic [2:0] state;
  logic [XLEN-1:0] pc, a, b, imm, alu_q, mdr, alu_res, wd, jt;
  logic [XLEN-1:0] rf [32];
  logic [31:0] ir, wcnt;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, wa;
  logic is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_halt, known, hs, to_hit, ret_n;
  assign op = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign funct = ir[5:0];
  assign is_r = op == 6'h00 && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                                funct == 6'h25 || funct == 6'h2A);
  assign is_addi = op == 6'h08;
  assign is_lw = op == 6'h23;
  assign is_sw = op == 6'h2B;
  assign is_beq = op == 6'h04;
  assign is_j = op == 6'h02;
  assign is_halt = op == 6'h3F;
  assign known = is_r || is_addi || is_lw || is_sw || is_beq || is_j || is_halt;
  assign jt = {{(XLEN-28){1'b0}}, ir[25:0], 2'b00};
  assign wa = is_r ? rd : rt;
  assign wd = is_lw ? mdr : alu_q;
  // Memory port is driven straight from held state so it cannot move during a wait
  assign mem_req = !reset && (state == S_FETCH || state == S_MEM);
  assign mem_we = state == S_MEM && is_sw;
  assign mem_addr = state == S_MEM ? alu_q : pc;
  assign mem_wdata = b;
  assign hs = mem_req && mem_ready;
  assign to_hit = MEM_TIMEOUT != 0 && mem_req && !mem_ready && wcnt == 32'(MEM_TIMEOUT - 1);
  assign ret_n = state == S_WB || (state == S_EXEC && (is_beq || is_j || is_halt || !known)) ||
                 (state == S_MEM && hs && is_sw);
  assign pc_out = pc;
  assign alu_out = alu_q;
  assign halted = state == S_HALT;
  // ALU: R-type by funct, everything else is base + immediate
  always_comb begin
    alu_res = !is_r ? a + imm :
              funct == 6'h20 ? a + b :
              funct == 6'h22 ? a - b :
              funct == 6'h24 ? a & b :
              funct == 6'h25 ? a | b :
              {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
  end
  // Sequencer, datapath registers and register file
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      imm <= '0;
      alu_q <= '0;
      mdr <= '0;
      wcnt <= '0;
      retired <= 1'b0;
      fault <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      retired <= ret_n;
      wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : '0;
      if (to_hit) begin
        state <= S_HALT;
        fault <= 1'b1;
      end else begin
        case (state)
          S_FETCH: if (hs) begin
            ir <= mem_rdata[31:0];
            pc <= pc + XLEN'(4);
            state <= S_DECODE;
          end
          S_DECODE: begin
            a <= rf[rs];
            b <= rf[rt];
            imm <= {{(XLEN-16){ir[15]}}, ir[15:0]};
            state <= S_EXEC;
          end
          S_EXEC: begin
            alu_q <= alu_res;
            if (is_beq && a == b) pc <= pc + (imm << 2);
            if (is_j) pc <= jt;
            state <= (is_r || is_addi) ? S_WB : (is_lw || is_sw) ? S_MEM : is_halt ? S_HALT : S_FETCH;
          end
          S_MEM: if (hs) begin
            mdr <= mem_rdata;
            state <= is_lw ? S_WB : S_FETCH;
          end
          S_WB: begin
            if (wa != 5'd0) rf[wa] <= wd;
            state <= S_FETCH;
          end
          S_HALT: state <= S_HALT;
          default: state <= S_HALT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed program tests with memory model and access log
module tb_multicycle_core;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  always #5 clock = ~clock;
  logic mem_req, mem_we, mem_ready, retired, halted, fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, alu_out;
  logic req2, we2, ret2, halt2, fault2;
  logic [31:0] addr2, wdata2, pc2, alu2;
  multicycle_core dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_out(pc_out),
    .alu_out(alu_out), .retired(retired), .halted(halted), .fault(fault)
  );
  multicycle_core #(.RESET_PC(32'h20), .MEM_TIMEOUT(4)) dut2 (
    .clock(clock), .reset(reset2), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
    .mem_wdata(wdata2), .mem_rdata(32'h0), .mem_ready(1'b0), .pc_out(pc2),
    .alu_out(alu2), .retired(ret2), .halted(halt2), .fault(fault2)
  );
  typedef struct {int cyc; logic [31:0] addr; logic we; logic [31:0] wdata;} acc_t;
  acc_t log_q[$];
  int cyc = 0, wcnt = 0, wait_n = 0, rcnt = 0, stab_err = 0, passed = 0, fails = 0, total = 0;
  logic pw = 1'b0;
  logic [64:0] pv;
  logic [31:0] mem [256];
  logic [31:0] wmem [256];
  logic wv [256];
  logic [7:0] idx;
  assign idx = mem_addr[9:2];
  assign mem_rdata = wv[idx] ? wmem[idx] : mem[idx];
  assign mem_ready = wcnt >= wait_n;
  // Memory model, wait-state counter, retire counter, stability monitor and access log
  always @(posedge clock) begin
    cyc <= cyc + 1;
    wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
    rcnt <= reset ? 0 : rcnt + int'(retired);
    if (pw && mem_req && {mem_addr, mem_we, mem_wdata} != pv) stab_err <= stab_err + 1;
    pw <= mem_req && !mem_ready;
    pv <= {mem_addr, mem_we, mem_wdata};
    if (reset) begin
      log_q.delete();
      for (int i = 0; i < 256; i++) wv[i] <= 1'b0;
    end else if (mem_req && mem_ready) begin
      log_q.push_back('{cyc, mem_addr, mem_we, mem_wdata});
      if (mem_we) begin
        wmem[idx] <= mem_wdata;
        wv[idx] <= 1'b1;
      end
    end
  end
  function automatic logic [31:0] r_i(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h0, 6'(fn)};
  endfunction
  function automatic logic [31:0] i_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] j_i(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic begin_test(input int w);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    wait_n = w;
  endtask
  task automatic run_halt(input string tag);
    int n = 0;
    while (!halted && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_halted"}, halted, 1);
  endtask
  task automatic idle_after_halt(input string tag, input int sz);
    repeat (5) @(negedge clock);
    chk({tag, "_no_req"}, mem_req, 0);
    chk({tag, "_log_frozen"}, log_q.size(), sz);
  endtask
  initial begin
    // reset state
    begin_test(0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_pc", pc_out, 0);
    // arithmetic program
    mem[0] = i_i(8, 0, 1, 5);
    mem[1] = i_i(8, 0, 2, -3);
    mem[2] = r_i(1, 2, 3, 32'h20);
    mem[3] = r_i(2, 1, 4, 32'h2A);
    mem[4] = i_i(32'h2B, 0, 3, 32'h80);
    mem[5] = i_i(32'h2B, 0, 4, 32'h84);
    mem[6] = j_i(32'h3F, 0);
    reset = 1'b0;
    #1 chk("first_fetch_req", mem_req, 1);
    run_halt("arith");
    repeat (2) @(negedge clock);
    chk("arith_retired", rcnt, 7);
    chk("arith_log_size", log_q.size(), 9);
    chk("add_result_addr", log_q[5].addr, 32'h80);
    chk("add_result_we", log_q[5].we, 1);
    chk("add_result", log_q[5].wdata, 2);
    chk("slt_result", log_q[7].wdata, 1);
    chk("addi_latency", log_q[1].cyc - log_q[0].cyc, 4);
    chk("rtype_latency", log_q[3].cyc - log_q[2].cyc, 4);
    chk("sw_latency", log_q[6].cyc - log_q[4].cyc, 4);
    idle_after_halt("arith", 9);
    // store / load with 3 wait states
    begin_test(3);
    mem[0] = i_i(8, 0, 1, 5);
    mem[1] = j_i(2, 4);
    mem[4] = i_i(32'h2B, 0, 1, 8);
    mem[5] = i_i(32'h23, 0, 5, 8);
    mem[6] = i_i(32'h2B, 0, 5, 12);
    mem[7] = j_i(32'h3F, 0);
    reset = 1'b0;
    run_halt("ldst");
    chk("ldst_log_size", log_q.size(), 9);
    chk("sw_addr", log_q[3].addr, 8);
    chk("sw_we", log_q[3].we, 1);
    chk("sw_data", log_q[3].wdata, 5);
    chk("lw_addr", log_q[5].addr, 8);
    chk("lw_we", log_q[5].we, 0);
    chk("lw_value_stored", log_q[7].wdata, 5);
    chk("addi_latency_wait3", log_q[1].cyc - log_q[0].cyc, 7);
    chk("stable_during_wait", stab_err, 0);
    // branches and unknown encodings
    begin_test(0);
    mem[0] = i_i(8, 0, 1, 1);
    mem[1] = i_i(8, 0, 2, 2);
    mem[2] = j_i(32'h3E, 0);
    mem[3] = r_i(1, 1, 1, 32'h3F);
    mem[4] = i_i(4, 1, 1, 2);
    mem[5] = j_i(32'h3F, 0);
    mem[6] = j_i(32'h3F, 0);
    mem[7] = i_i(4, 1, 2, 5);
    mem[8] = i_i(32'h2B, 0, 1, 32'h80);
    mem[9] = j_i(32'h3F, 0);
    reset = 1'b0;
    run_halt("br");
    chk("br_log_size", log_q.size(), 9);
    chk("beq_taken_target", log_q[5].addr, 32'h1C);
    chk("beq_not_taken_target", log_q[6].addr, 32'h20);
    chk("beq_latency", log_q[5].cyc - log_q[4].cyc, 3);
    chk("nop_latency", log_q[3].cyc - log_q[2].cyc, 3);
    chk("unknown_funct_no_write", log_q[7].wdata, 1);
    // jump and halt
    begin_test(0);
    mem[0] = j_i(2, 32'h40);
    mem[64] = j_i(32'h3F, 0);
    reset = 1'b0;
    run_halt("jmp");
    chk("j_target", log_q[1].addr, 32'h100);
    chk("j_latency", log_q[1].cyc - log_q[0].cyc, 3);
    idle_after_halt("jmp", 2);
    // reset during a pending load
    begin_test(3);
    mem[0] = i_i(32'h23, 0, 5, 32'h80);
    mem[32] = 32'h77;
    reset = 1'b0;
    begin
      int n = 0;
      while (!(mem_req && mem_addr == 32'h80) && n < 100) begin
        @(negedge clock);
        n++;
      end
    end
    chk("lw_pending_addr", mem_addr, 32'h80);
    @(negedge clock);
    chk("lw_still_waiting", mem_ready, 0);
    reset = 1'b1;
    #1 chk("rst_drops_req", mem_req, 0);
    @(negedge clock);
    chk("rst_pc_mid_lw", pc_out, 0);
    chk("rst_req_held_low", mem_req, 0);
    mem[0] = i_i(32'h2B, 0, 5, 32'h84);
    mem[1] = j_i(32'h3F, 0);
    reset = 1'b0;
    #1 chk("refetch_req", mem_req, 1);
    chk("refetch_addr", mem_addr, 0);
    run_halt("abort");
    chk("aborted_lw_no_write_addr", log_q[1].addr, 32'h84);
    chk("aborted_lw_no_write", log_q[1].wdata, 0);
    // memory timeout on the second core
    chk("to_rst_pc", pc2, 32'h20);
    chk("to_rst_req", req2, 0);
    reset2 = 1'b0;
    #1 chk("to_req_addr", addr2, 32'h20);
    repeat (3) @(negedge clock);
    chk("to_no_fault_yet", fault2, 0);
    chk("to_req_still", req2, 1);
    @(negedge clock);
    chk("to_fault", fault2, 1);
    chk("to_halted", halt2, 1);
    chk("to_req_dropped", req2, 0);
    chk("to_no_retire", ret2, 0);
    reset2 = 1'b1;
    @(negedge clock);
    chk("to_rst_fault_clr", fault2, 0);
    chk("to_rst_halt_clr", halt2, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
